// File: rtl/rat_add_sched_if.sv
// Bundle of requester, adder and response signals shared by the rational-add scheduler.
// slave is the scheduler's view; master is the clients-plus-adder side.
interface rat_add_sched_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_l_num;
  logic [NREQ*WIDTH-1:0] req_l_den;
  logic [NREQ*WIDTH-1:0] req_r_num;
  logic [NREQ*WIDTH-1:0] req_r_den;

  logic [WIDTH-1:0]      add_l_num;
  logic [WIDTH-1:0]      add_l_den;
  logic [WIDTH-1:0]      add_r_num;
  logic [WIDTH-1:0]      add_r_den;
  logic [WIDTH-1:0]      add_s_num;
  logic [WIDTH-1:0]      add_s_den;
  logic                  add_rdy;

  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_num;
  logic [WIDTH-1:0]      rsp_den;
  logic                  rsp_err;
  logic                  busy;

  modport slave (
    input  req_valid, req_l_num, req_l_den, req_r_num, req_r_den,
    input  add_s_num, add_s_den, add_rdy,
    output req_ready, add_l_num, add_l_den, add_r_num, add_r_den,
    output rsp_valid, rsp_id, rsp_num, rsp_den, rsp_err, busy
  );

  modport master (
    output req_valid, req_l_num, req_l_den, req_r_num, req_r_den,
    output add_s_num, add_s_den, add_rdy,
    input  req_ready, add_l_num, add_l_den, add_r_num, add_r_den,
    input  rsp_valid, rsp_id, rsp_num, rsp_den, rsp_err, busy
  );
endinterface

// File: rtl/rat_add_sched.sv
// Round-robin scheduler feeding one pipelined rational adder from NREQ requesters;
// a tag pipe follows each op so its result returns with requester id and error flag.
module rat_add_sched #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int LAT   = 2
) (
  input logic           clk,
  input logic           rst,
  rat_add_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic           err;
  } tag_t;

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_any;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   hi_id;
  logic [IDW-1:0]   lo_id;
  logic             hi_any;
  logic             lo_any;

  logic [WIDTH-1:0] sel_l_num, sel_l_den, sel_r_num, sel_r_den;
  logic             sel_err;
  logic [WIDTH-1:0] l_num_q, l_den_q, r_num_q, r_den_q;

  tag_t             tag [LAT+1];

  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_num_q, rsp_den_q;
  logic             rsp_err_q;
  logic             busy_c;

  // Lowest valid index above ptr wins; otherwise wrap to the lowest valid index overall.
  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    hi_any = 1'b0;
    hi_id  = '0;
    lo_any = 1'b0;
    lo_id  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_any = 1'b1;
        lo_id  = IDW'(i);
        if (IDW'(i) > ptr) begin
          hi_any = 1'b1;
          hi_id  = IDW'(i);
        end
      end
    end
    gnt_any = bus.add_rdy && !rst && lo_any;
    gnt_id  = hi_any ? hi_id : lo_id;
    grant   = '0;
    if (gnt_any) grant[gnt_id] = 1'b1;
  end

  always_comb begin
    sel_l_num = '0;
    sel_l_den = '0;
    sel_r_num = '0;
    sel_r_den = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_l_num = bus.req_l_num[i*WIDTH +: WIDTH];
        sel_l_den = bus.req_l_den[i*WIDTH +: WIDTH];
        sel_r_num = bus.req_r_num[i*WIDTH +: WIDTH];
        sel_r_den = bus.req_r_den[i*WIDTH +: WIDTH];
      end
    end
    sel_err = (sel_l_den == '0) || (sel_r_den == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= IDW'(NREQ - 1);
      l_num_q <= '0;
      l_den_q <= '0;
      r_num_q <= '0;
      r_den_q <= '0;
      // NOTE: the tag pipe is reset because its valid bits drive busy and rsp_valid.
      for (int s = 0; s <= LAT; s++) tag[s] <= '0;
    end else begin
      if (gnt_any) begin
        ptr     <= gnt_id;
        l_num_q <= sel_l_num;
        l_den_q <= sel_l_den;
        r_num_q <= sel_r_num;
        r_den_q <= sel_r_den;
      end
      tag[0] <= '{gnt_any, gnt_id, sel_err};
      for (int s = 1; s <= LAT; s++) tag[s] <= tag[s-1];
    end
  end

  // The last tag stage lines up with the adder result one edge before it is registered out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_num_q   <= '0;
      rsp_den_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= tag[LAT].vld;
      if (tag[LAT].vld) begin
        rsp_id_q  <= tag[LAT].id;
        rsp_err_q <= tag[LAT].err;
        rsp_num_q <= bus.add_s_num;
        rsp_den_q <= bus.add_s_den;
      end
    end
  end

  always_comb begin
    busy_c = 1'b0;
    for (int s = 0; s <= LAT; s++) busy_c = busy_c | tag[s].vld;
  end

  assign bus.req_ready = grant;
  assign bus.add_l_num = l_num_q;
  assign bus.add_l_den = l_den_q;
  assign bus.add_r_num = r_num_q;
  assign bus.add_r_den = r_den_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_num   = rsp_num_q;
  assign bus.rsp_den   = rsp_den_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_c;
endmodule

// File: tb/tb_rat_add_sched.sv
// Bench for rat_add_sched: behavioural 2-stage adder, scoreboard of expected responses
// pushed on each observed transfer and popped when rsp_valid is seen.
module tb_rat_add_sched;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;

  typedef struct {
    logic [1:0]       id;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    logic             err;
    int               due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rsp_seen = 0;
  exp_t sb[$];

  logic [WIDTH-1:0] a_ln, a_ld, a_rn, a_rd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rat_add_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  rat_add_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Adder model: operands sampled one edge after acceptance, result one edge later.
  always @(posedge clk) begin
    a_ln <= bus.add_l_num;
    a_ld <= bus.add_l_den;
    a_rn <= bus.add_r_num;
    a_rd <= bus.add_r_den;
    bus.add_s_num <= a_ln * a_rd + a_rn * a_ld;
    bus.add_s_den <= a_ld * a_rd;
  end

  function automatic exp_t model(input int id, input logic [WIDTH-1:0] ln, ld, rn, rd, input int due);
    exp_t e;
    logic [63:0] n;
    logic [63:0] d;
    n = {32'b0, ln} * {32'b0, rd} + {32'b0, rn} * {32'b0, ld};
    d = {32'b0, ld} * {32'b0, rd};
    e.id  = 2'(id);
    e.num = n[WIDTH-1:0];
    e.den = d[WIDTH-1:0];
    e.err = (ld == 0) || (rd == 0);
    e.due = due;
    return e;
  endfunction

  // Monitor: record transfers, match responses in order with exact latency.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.rsp_valid) begin
        rsp_seen++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got id=%0d num=%0h den=%0h at cyc %0d, expected no response",
                   bus.rsp_id, bus.rsp_num, bus.rsp_den, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (bus.rsp_id !== e.id || bus.rsp_num !== e.num || bus.rsp_den !== e.den ||
              bus.rsp_err !== e.err || cyc != e.due) begin
            errors++;
            $display("FAIL rsp: got id=%0d num=%0h den=%0h err=%0b cyc=%0d, expected id=%0d num=%0h den=%0h err=%0b cyc=%0d",
                     bus.rsp_id, bus.rsp_num, bus.rsp_den, bus.rsp_err, cyc,
                     e.id, e.num, e.den, e.err, e.due);
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i])
          sb.push_back(model(i, bus.req_l_num[i*WIDTH +: WIDTH], bus.req_l_den[i*WIDTH +: WIDTH],
                             bus.req_r_num[i*WIDTH +: WIDTH], bus.req_r_den[i*WIDTH +: WIDTH],
                             cyc + LAT + 2));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic set_op(input int id, input logic [WIDTH-1:0] ln, ld, rn, rd);
    bus.req_l_num[id*WIDTH +: WIDTH] = ln;
    bus.req_l_den[id*WIDTH +: WIDTH] = ld;
    bus.req_r_num[id*WIDTH +: WIDTH] = rn;
    bus.req_r_den[id*WIDTH +: WIDTH] = rd;
  endtask

  // Present one op from requester id and hold it until granted; returns at posedge+1.
  task automatic issue(input int id, input logic [WIDTH-1:0] ln, ld, rn, rd);
    bit got = 0;
    set_op(id, ln, ld, rn, rd);
    bus.req_valid[id] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_wait: requester %0d got no grant in 20 cycles, expected a grant", id);
    end
    @(posedge clk);
    #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (!bus.busy && !bus.rsp_valid && sb.size() == 0) begin
        idle = 1;
        break;
      end
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL idle_wait: busy=%0b pending=%0d after 60 cycles, expected drained", bus.busy, sb.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.add_rdy = 1'b1;
    issue(1, 32'd7, 32'd3, 32'd2, 32'd5);
    for (int i = 0; i < NREQ; i++) set_op(i, 32'd9, 32'd9, 32'd9, 32'd9);
    bus.req_valid = 4'b1111;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.add_l_num !== 0 || bus.add_r_den !== 0 ||
        bus.rsp_valid !== 1'b0 || bus.rsp_num !== 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b add_l_num=%0h add_r_den=%0h rsp_valid=%0b rsp_num=%0h busy=%0b, expected all 0",
               bus.req_ready, bus.add_l_num, bus.add_r_den, bus.rsp_valid, bus.rsp_num, bus.busy);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: ready=%b, expected 0001", bus.req_ready);
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_no_rdy();
    bus.add_rdy   = 1'b0;
    bus.req_valid = 4'b1111;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL no_rdy: ready=%b busy=%0b, expected ready=0000 busy=0", bus.req_ready, bus.busy);
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0000;
    bus.add_rdy   = 1'b1;
  endtask

  task automatic test_single();
    int seen0 = rsp_seen;
    issue(1, 32'd1, 32'd2, 32'd1, 32'd3);
    wait_idle();
    checks++;
    if (rsp_seen - seen0 != 1 || bus.rsp_num !== 32'd5 || bus.rsp_den !== 32'd6 ||
        bus.rsp_id !== 2'd1 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single: rsps=%0d num=%0d den=%0d id=%0d err=%0b, expected rsps=1 num=5 den=6 id=1 err=0",
               rsp_seen - seen0, bus.rsp_num, bus.rsp_den, bus.rsp_id, bus.rsp_err);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 32'(i + 2), 32'd1, 32'd1);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_rdy = 4'b0001 << (k % NREQ);
      checks++;
      if (bus.req_ready !== exp_rdy || (k > 0 && bus.busy !== 1'b1)) begin
        errors++;
        $display("FAIL rr_grant[%0d]: ready=%b busy=%0b, expected ready=%b busy=%0b",
                 k, bus.req_ready, bus.busy, exp_rdy, k > 0);
      end
    end
    @(posedge clk);
    #1 bus.add_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rdy_drop: ready=%b busy=%0b, expected ready=0000 busy=1", bus.req_ready, bus.busy);
    end
    wait_idle();
    bus.req_valid = 4'b0000;
    bus.add_rdy   = 1'b1;
  endtask

  task automatic test_err();
    issue(2, 32'd3, 32'd0, 32'd1, 32'd4);
    issue(3, 32'd1, 32'd1, 32'd1, 32'd0);
    issue(2, 32'd1, 32'd4, 32'd1, 32'd4);
    wait_idle();
    checks++;
    if (bus.rsp_err !== 1'b0 || bus.rsp_id !== 2'd2 || bus.rsp_num !== 32'd8 || bus.rsp_den !== 32'd16) begin
      errors++;
      $display("FAIL err_clear: err=%0b id=%0d num=%0d den=%0d, expected err=0 id=2 num=8 den=16",
               bus.rsp_err, bus.rsp_id, bus.rsp_num, bus.rsp_den);
    end
  endtask

  task automatic test_wrap_and_flush();
    int seen0;
    issue(0, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1);
    wait_idle();
    checks++;
    if (bus.rsp_num !== 32'd0 || bus.rsp_den !== 32'd1 || bus.rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL wrap: num=%0h den=%0h id=%0d, expected num=0 den=1 id=0", bus.rsp_num, bus.rsp_den, bus.rsp_id);
    end
    set_op(0, 32'd2, 32'd3, 32'd4, 32'd5);
    set_op(1, 32'd6, 32'd7, 32'd8, 32'd9);
    @(posedge clk);
    #1 bus.req_valid = 4'b0011;
    @(posedge clk);
    @(posedge clk);
    #1 bus.req_valid = 4'b0000;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy: busy=%0b, expected 1 with two ops in flight", bus.busy);
    end
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    seen0 = rsp_seen;
    repeat (8) @(negedge clk);
    checks++;
    if (rsp_seen != seen0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush: rsps=%0d busy=%0b after reset, expected rsps=0 busy=0", rsp_seen - seen0, bus.busy);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.add_rdy   = 1'b0;
    bus.req_valid = '0;
    bus.req_l_num = '0;
    bus.req_l_den = '0;
    bus.req_r_num = '0;
    bus.req_r_den = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    test_reset();
    test_no_rdy();
    test_single();
    test_round_robin();
    test_err();
    test_wrap_and_flush();

    wait_idle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
